mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 255, max cycles in a BUSY state awaiting MemDone before timeout (1..65535).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 IReq  input  1  instruction-fetch read request; IAdr  input  32  fetch byte address.
REQ-005 IGnt  output  1  fetch request accepted; IRdValid  output  1  fetch data valid; IRdData  output  32  fetch data.
REQ-006 DReq  input  1  data request; DAdr  input  32  data address; DWriteEn  input  1  1=store, 0=load.
REQ-007 DWriteByteEn  input  4  store byte lanes; DWriteData  input  32  store data.
REQ-008 DGnt  output  1  data request accepted; DDone  output  1  data access complete; DRdData  output  32  load data.
REQ-009 MemEn  output  1  memory access active; MemAdr  output  32; MemWriteEn  output  1; MemWriteByteEn  output  4; MemWriteData  output  32.
REQ-010 MemDone  input  1  memory completes current access this cycle; MemReadData  input  32  read data, valid with MemDone.
REQ-011 BusErr  output  1  sticky timeout flag.

Function
REQ-012 FSM states SHALL be IDLE, IBUSY, DBUSY; exactly one transaction outstanding at any time.
REQ-013 In IDLE with any request, the arbiter SHALL assert exactly one of IGnt/DGnt combinationally in that cycle, register the winner's address/attributes, and enter IBUSY or DBUSY on the next edge.
REQ-014 IGnt/DGnt SHALL be asserted only in IDLE; requesters hold Req and attributes stable until granted.
REQ-015 In IBUSY/DBUSY, MemEn SHALL be 1 and Mem* outputs SHALL drive the registered values, constant until exit.
REQ-016 IBUSY forces MemWriteEn=0 and MemWriteByteEn=0000.
REQ-017 On MemDone in IBUSY: IRdValid=1 and IRdData=MemReadData that cycle; in DBUSY: DDone=1 and DRdData=MemReadData; then return to IDLE.
REQ-018 Minimum grant-to-completion latency SHALL be 1 cycle (grant cycle N, MemDone at N+1, done pulse at N+1); back-to-back grants occur every 2 cycles minimum.
REQ-019 MemDone in IDLE SHALL be ignored; IRdValid/DDone SHALL never assert outside the matching BUSY state.
REQ-020 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without MemDone; reaching MAX_WAIT SHALL set BusErr, pulse the owner's done signal with read data 0, and return to IDLE.
REQ-021 MemDone in the same cycle the counter reaches MAX_WAIT SHALL count as normal completion; BusErr stays 0.
REQ-022 BusErr SHALL remain 1 until reset.
REQ-023 IRdData/DRdData SHALL be 0 when their valid/done signal is 0.

Reset
REQ-024 reset low SHALL immediately force state IDLE, MemEn=0, all Mem* outputs 0, IGnt=DGnt=IRdValid=DDone=0, BusErr=0, wait counter 0, priority pointer to data.
REQ-025 Reset mid-transaction SHALL abandon it with no done pulse; operation resumes on the first clk edge after reset deasserts.

Configuration
REQ-026 Macro MEM_ARBITER_RR_EN: defined -> a priority pointer toggles to the other requester after each grant; when IReq and DReq both assert in IDLE, the pointed-to requester wins.
REQ-027 MEM_ARBITER_RR_EN undefined -> fixed priority, data always wins simultaneous requests; no pointer state.

Verification
REQ-028 IReq=1, IAdr=0x100, MemDone one cycle after grant with MemReadData=0x00500093 -> IGnt cycle N, MemAdr=0x100 MemWriteEn=0 cycle N+1, IRdValid=1 IRdData=0x00500093 cycle N+1.
REQ-029 DReq store DAdr=0x2004, DWriteByteEn=0011, DWriteData=0xDEADBEEF, MemDone after 3 BUSY cycles -> MemEn/MemWriteEn=1 with those values held 3 cycles, DDone pulse once.
REQ-030 IReq and DReq held together for 4 transactions -> without macro DGnt wins all while DReq stays high; with macro grants alternate D,I,D,I.
REQ-031 MAX_WAIT=4, DReq load, MemDone never asserted -> DDone=1 with DRdData=0 on the 4th BUSY cycle, BusErr=1 sticky, next request granted normally.
REQ-032 reset low during DBUSY -> MemEn=0 immediately, no DDone; after release IReq granted from IDLE.
REQ-033 MemDone pulsed in IDLE with no requests -> no IRdValid/DDone, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the two-requester memory arbiter.
interface mem_arbiter_if;
  logic        IReq;
  logic [31:0] IAdr;
  logic        IGnt;
  logic        IRdValid;
  logic [31:0] IRdData;
  logic        DReq;
  logic [31:0] DAdr;
  logic        DWriteEn;
  logic [3:0]  DWriteByteEn;
  logic [31:0] DWriteData;
  logic        DGnt;
  logic        DDone;
  logic [31:0] DRdData;
  logic        MemEn;
  logic [31:0] MemAdr;
  logic        MemWriteEn;
  logic [3:0]  MemWriteByteEn;
  logic [31:0] MemWriteData;
  logic        MemDone;
  logic [31:0] MemReadData;
  logic        BusErr;
  modport slave (
    input  IReq, IAdr, DReq, DAdr, DWriteEn, DWriteByteEn, DWriteData, MemDone, MemReadData,
    output IGnt, IRdValid, IRdData, DGnt, DDone, DRdData,
           MemEn, MemAdr, MemWriteEn, MemWriteByteEn, MemWriteData, BusErr
  );
  modport master (
    output IReq, IAdr, DReq, DAdr, DWriteEn, DWriteByteEn, DWriteData, MemDone, MemReadData,
    input  IGnt, IRdValid, IRdData, DGnt, DDone, DRdData,
           MemEn, MemAdr, MemWriteEn, MemWriteByteEn, MemWriteData, BusErr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding fetch/data memory arbiter with wait timeout and sticky BusErr.
// MEM_ARBITER_RR_EN selects round-robin between simultaneous requests; otherwise data wins.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;
  state_t      state;
  logic [15:0] wait_cnt;
  logic [31:0] adr, wdata;
  logic [3:0]  be;
  logic        we, err, idle, pick_d, tmo, fin;
`ifdef MEM_ARBITER_RR_EN
  logic ptr_d;
  assign pick_d = bus.DReq && (!bus.IReq || ptr_d);
`else
  assign pick_d = bus.DReq;
`endif
  assign idle = state == IDLE;
  // MemDone on the last allowed cycle wins over the timeout
  assign tmo  = !bus.MemDone && wait_cnt == 16'(MAX_WAIT - 1);
  assign fin  = bus.MemDone || tmo;
  assign bus.DGnt           = idle && pick_d;
  assign bus.IGnt           = idle && bus.IReq && !pick_d;
  assign bus.IRdValid       = state == IBUSY && fin;
  assign bus.DDone          = state == DBUSY && fin;
  assign bus.IRdData        = state == IBUSY && bus.MemDone ? bus.MemReadData : '0;
  assign bus.DRdData        = state == DBUSY && bus.MemDone ? bus.MemReadData : '0;
  assign bus.MemEn          = !idle;
  assign bus.MemAdr         = adr;
  assign bus.MemWriteEn     = we;
  assign bus.MemWriteByteEn = be;
  assign bus.MemWriteData   = wdata;
  assign bus.BusErr         = err;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err      <= 1'b0;
      adr      <= '0;
      we       <= 1'b0;
      be       <= '0;
      wdata    <= '0;
`ifdef MEM_ARBITER_RR_EN
      ptr_d    <= 1'b1;
`endif
    end else if (idle) begin
      wait_cnt <= '0;
      if (bus.DGnt) begin
        state <= DBUSY;
        adr   <= bus.DAdr;
        we    <= bus.DWriteEn;
        be    <= bus.DWriteByteEn;
        wdata <= bus.DWriteData;
      end else if (bus.IGnt) begin
        state <= IBUSY;
        adr   <= bus.IAdr;
        we    <= 1'b0;
        be    <= '0;
        wdata <= '0;
      end
`ifdef MEM_ARBITER_RR_EN
      if (bus.DGnt || bus.IGnt) ptr_d <= bus.IGnt;
`endif
    end else if (fin) begin
      state <= IDLE;
      err   <= err | tmo;
      adr   <= '0;
      we    <= 1'b0;
      be    <= '0;
      wdata <= '0;
    end else begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions with a completion scoreboard, plus idle, reset and contention sequences.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.MAX_WAIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          is_d;
    logic [31:0] adr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    bit          err;
  } vec_t;
  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_check(input bit is_d, input logic [31:0] data);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: completion on %s with 0x%0h but nothing expected", is_d ? "D" : "I", data);
    end else begin
      e = sb.pop_front();
      if (e.is_d !== is_d || e.data !== data) begin
        errors++;
        $display("FAIL sb_data: got %s 0x%0h expected %s 0x%0h", is_d ? "D" : "I", data,
                 e.is_d ? "D" : "I", e.data);
      end
    end
  endtask

  task automatic idle_in();
    bus.IReq = 0; bus.IAdr = '0; bus.DReq = 0; bus.DAdr = '0; bus.DWriteEn = 0;
    bus.DWriteByteEn = '0; bus.DWriteData = '0; bus.MemDone = 0; bus.MemReadData = '0;
  endtask

  task automatic run_txn(input vec_t v);
    int   done_at;
    logic done;
    done_at = v.lat <= 4 ? v.lat : 4;
    @(negedge clk);
    bus.IReq = !v.is_d; bus.DReq = v.is_d;
    bus.IAdr = v.is_d ? 32'hFFFF_FFF0 : v.adr; bus.DAdr = v.is_d ? v.adr : 32'hEEEE_EEE0;
    bus.DWriteEn = v.we; bus.DWriteByteEn = v.be; bus.DWriteData = v.wd; bus.MemDone = 0;
    sb.push_back('{v.is_d, v.lat <= 4 ? v.rd : 32'h0});
    #1;
    chk("dgnt", bus.DGnt, v.is_d);
    chk("ignt", bus.IGnt, !v.is_d);
    chk("memen_idle", bus.MemEn, 0);
    for (int k = 1; k <= done_at; k++) begin
      @(negedge clk);
      bus.IReq = 0; bus.DReq = 0;
      bus.MemDone = k == v.lat;
      bus.MemReadData = k == v.lat ? v.rd : ($urandom | 32'h1);
      #1;
      chk("memen", bus.MemEn, 1);
      chk("memadr", bus.MemAdr, v.adr);
      chk("memwe", bus.MemWriteEn, v.is_d & v.we);
      chk("membe", bus.MemWriteByteEn, v.is_d ? v.be : 4'h0);
      if (v.is_d) chk("memwd", bus.MemWriteData, v.wd);
      chk("ignt_busy", bus.IGnt | bus.DGnt, 0);
      done = v.is_d ? bus.DDone : bus.IRdValid;
      chk("done", done, k == done_at);
      chk("other_done", v.is_d ? bus.IRdValid : bus.DDone, 0);
      if (done) sb_check(v.is_d, v.is_d ? bus.DRdData : bus.IRdData);
      else chk("rdata_zero", bus.IRdData | bus.DRdData, 0);
    end
    @(negedge clk);
    bus.MemDone = 0;
    #1;
    chk("buserr", bus.BusErr, v.err);
    chk("memen_after", bus.MemEn, 0);
    chk("memadr_after", bus.MemAdr, 0);
  endtask

  initial begin
    bit exp_d;
    tbl[0] = '{0, 32'h0000_0100, 0, 4'h0, 32'h0,         32'h0050_0093, 1, 0};
    tbl[1] = '{1, 32'h0000_2004, 1, 4'h3, 32'hDEAD_BEEF, 32'h0,         3, 0};
    tbl[2] = '{1, 32'h0000_3000, 0, 4'h0, 32'h0,         32'h1234_5678, 2, 0};
    tbl[3] = '{0, 32'h0000_0104, 0, 4'h0, 32'h0,         32'hA5A5_0104, 4, 0};
    tbl[4] = '{1, 32'h0000_4000, 0, 4'h0, 32'h0,         32'h0,         9, 1};
    tbl[5] = '{0, 32'h0000_0108, 0, 4'h0, 32'h0,         32'hCAFE_F00D, 1, 1};
    idle_in();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_memen", bus.MemEn, 0);
    chk("rst_memadr", bus.MemAdr, 0);
    chk("rst_done", bus.IRdValid | bus.DDone, 0);
    chk("rst_buserr", bus.BusErr, 0);
    @(negedge clk);
    reset = 1;

    @(negedge clk);
    bus.MemDone = 1; bus.MemReadData = 32'hFFFF_FFFF;
    #1;
    chk("idle_memdone_valid", bus.IRdValid | bus.DDone, 0);
    chk("idle_memdone_data", bus.IRdData | bus.DRdData, 0);
    chk("idle_memdone_memen", bus.MemEn, 0);
    @(negedge clk);
    bus.MemDone = 0;
    #1 chk("idle_stays", bus.MemEn, 0);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    @(negedge clk);
    bus.DReq = 1; bus.DAdr = 32'h5000; bus.DWriteEn = 0;
    #1 chk("rst_txn_dgnt", bus.DGnt, 1);
    @(negedge clk);
    bus.DReq = 0;
    #1 chk("rst_txn_busy", bus.MemEn, 1);
    #2 reset = 0;
    #1;
    chk("rst_mid_memen", bus.MemEn, 0);
    chk("rst_mid_ddone", bus.DDone, 0);
    chk("rst_mid_memadr", bus.MemAdr, 0);
    chk("rst_mid_buserr", bus.BusErr, 0);
    @(negedge clk);
    reset = 1;
    run_txn('{0, 32'h0000_0600, 0, 4'h0, 32'h0, 32'h0600_0600, 1, 0});

    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_d = t % 2 == 0;
`else
      exp_d = 1;
`endif
      @(negedge clk);
      bus.IReq = 1; bus.DReq = 1; bus.IAdr = 32'h400 + 32'(t * 4); bus.DAdr = 32'h800 + 32'(t * 4);
      bus.DWriteEn = 0; bus.MemDone = 0;
      sb.push_back('{exp_d, 32'h1000 + 32'(t)});
      #1;
      chk("both_dgnt", bus.DGnt, exp_d);
      chk("both_ignt", bus.IGnt, !exp_d);
      @(negedge clk);
      bus.MemDone = 1; bus.MemReadData = 32'h1000 + 32'(t);
      #1;
      chk("both_memadr", bus.MemAdr, exp_d ? bus.DAdr : bus.IAdr);
      chk("both_done", exp_d ? bus.DDone : bus.IRdValid, 1);
      if (bus.DDone) sb_check(1, bus.DRdData);
      else if (bus.IRdValid) sb_check(0, bus.IRdData);
    end
    @(negedge clk);
    idle_in();
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
